// File: rtl/hog_svm_mc.sv
// Multi-class streaming SVM scorer: per-window dot products against N_CLS coefficient
// banks, per-class bias, argmax over the class scores and a result FIFO with backpressure.
module hog_svm_mc #(
    parameter int FEA_I = 4,
    parameter int FEA_F = 16,
    parameter int N_FEA = 3780,
    parameter int N_CLS = 4,
    parameter int N_SW  = 1200,
    parameter int SW_W  = 11,
    parameter int RES_D = 4,
    localparam int FEA_W = FEA_I + FEA_F,
    localparam int IDX_W = $clog2(N_FEA),
    localparam int CLS_W = (N_CLS > 1) ? $clog2(N_CLS) : 1,
    localparam int ACC_W = 2 * FEA_W + IDX_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [FEA_W-1:0]        fea,
    input  logic                    cfg_we,
    input  logic [CLS_W-1:0]        cfg_cls,
    input  logic [IDX_W-1:0]        cfg_addr,
    input  logic [FEA_W-1:0]        cfg_wdata,
    output logic [FEA_W-1:0]        cfg_rdata,
    input  logic                    b_load,
    input  logic [FEA_W-1:0]        bias,
    input  logic                    sw_clr,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic [CLS_W-1:0]        cls_id,
    output logic signed [ACC_W-1:0] score,
    output logic                    detect,
    output logic [SW_W-1:0]         sw_id,
    output logic [1:0]              dbg_state
);

    localparam int PROD_W = 2 * FEA_W;
    localparam int PTR_W  = $clog2(RES_D);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ENT_W  = CLS_W + ACC_W + 1 + SW_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_PUSH = 2'd2;

    // Handshakes: a feature beat transfers on a rising edge where i_valid & i_ready
    // (and no sw_clr); a result transfers where o_valid & o_ready. Neither ready
    // depends on its own valid, and o_* are held while o_valid & !o_ready.

    logic [FEA_W-1:0]        coef_mem [N_CLS][N_FEA];
    logic signed [FEA_W-1:0] coef_q   [N_CLS];
    logic signed [PROD_W-1:0] prod_q  [N_CLS];
    logic signed [ACC_W-1:0] acc_q    [N_CLS];
    logic signed [ACC_W-1:0] sc_q     [N_CLS];
    logic signed [FEA_W-1:0] bias_q   [N_CLS];
    logic [ENT_W-1:0]        fifo_mem [RES_D];

    logic                    accept, last_beat, win_end, keep_win, push, pop, best_det;
    logic [IDX_W-1:0]        idx_q;
    logic                    v0_q, last0_q, v1_q, last1_q;
    logic signed [FEA_W-1:0] fea_q;
    logic [FEA_W-1:0]        cfg_rdata_q;
    logic [SW_W-1:0]         win_id_q, id0_q, id1_q, sc_id_q;
    logic [1:0]              state_q, state_d;
    logic [CLS_W-1:0]        scan_q, scan_d, best_cls_q, best_cls_d;
    logic signed [ACC_W-1:0] best_q, best_d;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q, inflight_q;

    assign accept    = i_valid & i_ready & ~sw_clr;
    assign last_beat = (idx_q == IDX_W'(N_FEA - 1));
    assign win_end   = v1_q & last1_q;
    // A completed window whose last beat is still in S0 survives sw_clr.
    assign keep_win  = v0_q & last0_q;

    // Coefficient banks, S0 datapath read and multiplier stage (no reset needed).
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            coef_mem[cfg_cls][cfg_addr] <= cfg_wdata;
        end
        for (int c = 0; c < N_CLS; c++) begin
            if (accept) begin
                coef_q[c] <= coef_mem[c][idx_q];
            end
            prod_q[c] <= PROD_W'(fea_q) * PROD_W'(coef_q[c]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_rdata_q <= '0;
        end else begin
            cfg_rdata_q <= coef_mem[cfg_cls][cfg_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= '0;
            v0_q     <= 1'b0;
            last0_q  <= 1'b0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            fea_q    <= '0;
            win_id_q <= '0;
            id0_q    <= '0;
            id1_q    <= '0;
        end else begin
            v0_q    <= accept;
            last0_q <= accept & last_beat;
            if (accept) begin
                fea_q <= fea;
            end
            v1_q    <= v0_q & (~sw_clr | last0_q);
            last1_q <= v0_q & last0_q;
            if (sw_clr) begin
                idx_q <= '0;
            end else if (accept) begin
                idx_q <= last_beat ? '0 : idx_q + 1'b1;
            end
            // Window ids are bound when the last beat is accepted.
            if (accept & last_beat) begin
                id0_q <= win_id_q;
            end
            if (last0_q) begin
                id1_q <= id0_q;
            end
            if (sw_clr) begin
                win_id_q <= '0;
            end else if (accept & last_beat) begin
                win_id_q <= (win_id_q == SW_W'(N_SW - 1)) ? '0 : win_id_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < N_CLS; c++) begin
                acc_q[c]  <= '0;
                sc_q[c]   <= '0;
                bias_q[c] <= '0;
            end
            sc_id_q <= '0;
        end else begin
            for (int c = 0; c < N_CLS; c++) begin
                if (b_load && (cfg_cls == CLS_W'(c))) begin
                    bias_q[c] <= bias;
                end
                if (win_end) begin
                    sc_q[c]  <= acc_q[c] + ACC_W'(prod_q[c]) + (ACC_W'(bias_q[c]) <<< FEA_F);
                    acc_q[c] <= '0;
                end else if (sw_clr && !keep_win) begin
                    acc_q[c] <= '0;
                end else if (v1_q) begin
                    acc_q[c] <= acc_q[c] + ACC_W'(prod_q[c]);
                end
            end
            if (win_end) begin
                sc_id_q <= id1_q;
            end
        end
    end

    // Argmax: strict > keeps the lowest index on ties.
    always_comb begin
        state_d    = state_q;
        scan_d     = scan_q;
        best_d     = best_q;
        best_cls_d = best_cls_q;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_end) begin
                    state_d = ST_SCAN;
                    scan_d  = '0;
                end
            end
            ST_SCAN: begin
                if ((scan_q == '0) || (sc_q[scan_q] > best_q)) begin
                    best_d     = sc_q[scan_q];
                    best_cls_d = scan_q;
                end
                if (scan_q == CLS_W'(N_CLS - 1)) begin
                    state_d = ST_PUSH;
                end else begin
                    scan_d = scan_q + 1'b1;
                end
            end
            ST_PUSH: begin
                push    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            scan_q     <= '0;
            best_q     <= '0;
            best_cls_q <= '0;
        end else begin
            state_q    <= state_d;
            scan_q     <= scan_d;
            best_q     <= best_d;
            best_cls_q <= best_cls_d;
        end
    end

    assign best_det = ~best_q[ACC_W-1] & (|best_q);
    assign pop      = (cnt_q != '0) & o_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {best_cls_q, best_q, best_det, sc_id_q};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q      <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            inflight_q <= inflight_q + CNT_W'(accept & last_beat) - CNT_W'(push);
        end
    end

    // Reserving a slot per window in flight means a push always finds room.
    assign i_ready   = (CNT_W'(RES_D) - cnt_q) > inflight_q;
    assign o_valid   = (cnt_q != '0);
    assign {cls_id, score, detect, sw_id} = o_valid ? fifo_mem[rd_ptr_q] : '0;
    assign cfg_rdata = cfg_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_hog_svm_mc.sv
// Directed bench for hog_svm_mc: small windows, hand-computed class scores,
// backpressure, id wrap, sw_clr, mid-window reset and coefficient readback.
`timescale 1ns/1ps
module tb_hog_svm_mc;

    localparam int FEA_I = 8;
    localparam int FEA_F = 16;
    localparam int N_FEA = 16;
    localparam int N_CLS = 4;
    localparam int N_SW  = 6;
    localparam int SW_W  = 3;
    localparam int RES_D = 4;
    localparam int FEA_W = FEA_I + FEA_F;
    localparam int IDX_W = 4;
    localparam int CLS_W = 2;
    localparam int ACC_W = 2 * FEA_W + IDX_W;
    localparam int LIMIT = 2000;

    // 1.0 and -0.5 in feature format; scores below are in units of 1<<32.
    localparam logic [FEA_W-1:0] F_ONE  = FEA_W'(32'sd65536);
    localparam logic [FEA_W-1:0] F_MHALF = FEA_W'(-32'sd32768);

    logic                    clk, rst;
    logic                    i_valid, i_ready;
    logic [FEA_W-1:0]        fea;
    logic                    cfg_we;
    logic [CLS_W-1:0]        cfg_cls;
    logic [IDX_W-1:0]        cfg_addr;
    logic [FEA_W-1:0]        cfg_wdata, cfg_rdata;
    logic                    b_load;
    logic [FEA_W-1:0]        bias;
    logic                    sw_clr;
    logic                    o_valid, o_ready;
    logic [CLS_W-1:0]        cls_id;
    logic signed [ACC_W-1:0] score;
    logic                    detect;
    logic [SW_W-1:0]         sw_id;
    logic [1:0]              dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int beats_acc = 0;
    logic [SW_W-1:0] exp_q[$];

    hog_svm_mc #(
        .FEA_I(FEA_I), .FEA_F(FEA_F), .N_FEA(N_FEA), .N_CLS(N_CLS),
        .N_SW(N_SW), .SW_W(SW_W), .RES_D(RES_D)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .fea(fea),
        .cfg_we(cfg_we), .cfg_cls(cfg_cls), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .b_load(b_load), .bias(bias), .sw_clr(sw_clr),
        .o_valid(o_valid), .o_ready(o_ready),
        .cls_id(cls_id), .score(score), .detect(detect), .sw_id(sw_id),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic cfg_write(input int cls, input int addr, input int val);
        cfg_we    = 1'b1;
        cfg_cls   = CLS_W'(cls);
        cfg_addr  = IDX_W'(addr);
        cfg_wdata = FEA_W'(val <<< FEA_F);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_bank(input int cls, input int mult);
        for (int a = 0; a < N_FEA; a++) cfg_write(cls, a, mult);
    endtask

    task automatic load_bias(input int cls, input int val);
        b_load  = 1'b1;
        cfg_cls = CLS_W'(cls);
        bias    = FEA_W'(val <<< FEA_F);
        @(negedge clk);
        b_load = 1'b0;
    endtask

    task automatic send_beat(input logic [FEA_W-1:0] v);
        int n;
        n = 0;
        i_valid = 1'b1;
        fea     = v;
        while (!i_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("beat_wait_timeout", i_ready, 1);
        @(negedge clk);
        beats_acc++;
    endtask

    task automatic send_window(input logic [FEA_W-1:0] v);
        for (int b = 0; b < N_FEA; b++) send_beat(v);
        i_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) check("result_timeout", o_valid, 1);
    endtask

    task automatic check_result(input string tag, input int e_cls, input logic signed [63:0] e_sc,
                                input int e_det, input int e_id);
        check({tag, "_valid"}, o_valid, 1);
        check({tag, "_cls"}, cls_id, e_cls);
        check({tag, "_score"}, score, e_sc);
        check({tag, "_detect"}, detect, e_det);
        check({tag, "_sw_id"}, sw_id, e_id);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst = 1'b1; i_valid = 1'b0; fea = '0; cfg_we = 1'b0; cfg_cls = '0;
        cfg_addr = '0; cfg_wdata = '0; b_load = 1'b0; bias = '0; sw_clr = 1'b0;
        o_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_i_ready", i_ready, 1);
        check("rst_o_valid", o_valid, 0);
        check("rst_cls_id", cls_id, 0);
        check("rst_score", score, 0);
        check("rst_detect", detect, 0);
        check("rst_sw_id", sw_id, 0);
        check("rst_cfg_rdata", cfg_rdata, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b1;
        @(negedge clk);

        // Banks c = c+1, features 1.0: scores 16,32,48,64.
        for (int c = 0; c < N_CLS; c++) load_bank(c, c + 1);
        send_window(F_ONE);
        wait_result(lat);
        check("t1_latency", lat, N_CLS + 3);
        check_result("t1", 3, 64'sd64 <<< 32, 1, 0);

        // Features -0.5: scores -8,-16,-24,-32, bias 100 on class 0.
        load_bias(0, 100);
        send_window(F_MHALF);
        wait_result(lat);
        check_result("t2_bias", 0, 64'sd92 <<< 32, 1, 1);
        load_bias(0, 0);
        send_window(F_MHALF);
        wait_result(lat);
        check_result("t2_neg", 0, -(64'sd8 <<< 32), 0, 2);

        // Tie between banks 1 and 2: scores 16,48,48,32.
        load_bank(0, 1); load_bank(1, 3); load_bank(2, 3); load_bank(3, 2);
        send_window(F_ONE);
        wait_result(lat);
        check_result("t3_tie", 1, 64'sd48 <<< 32, 1, 3);

        // Backpressure: six windows against a stalled consumer.
        sw_clr = 1'b1;
        @(negedge clk);
        sw_clr = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back(SW_W'(i));
        beats_acc = 0;
        fork
            begin
                for (int w = 0; w < 6; w++) send_window(F_ONE);
            end
            begin
                int n_pop;
                int guard;
                logic [SW_W-1:0] e_id;
                repeat (200) @(negedge clk);
                check("bp_i_ready_low", i_ready, 0);
                check("bp_beats_before_stall", beats_acc, 4 * N_FEA);
                check("bp_o_valid", o_valid, 1);
                check("bp_head_sw_id", sw_id, 0);
                o_ready = 1'b1;
                n_pop = 0;
                guard = 0;
                while (n_pop < 6 && guard < LIMIT) begin
                    if (o_valid) begin
                        e_id = exp_q.pop_front();
                        check("bp_sw_id", sw_id, e_id);
                        check("bp_score", score, 64'sd48 <<< 32);
                        n_pop++;
                    end
                    @(negedge clk);
                    guard++;
                end
                check("bp_pop_count", n_pop, 6);
                o_ready = 1'b0;
            end
        join

        // Seventh window wraps the id back to 0.
        send_window(F_ONE);
        wait_result(lat);
        check_result("t5_wrap", 1, 64'sd48 <<< 32, 1, 0);

        // sw_clr mid-window with a colliding beat: partial window is dropped.
        for (int b = 0; b < 5; b++) send_beat(F_ONE);
        fea    = F_ONE;
        sw_clr = 1'b1;
        @(negedge clk);
        sw_clr  = 1'b0;
        i_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("clr_no_result", o_valid, 0);
        send_window(F_ONE);
        wait_result(lat);
        check_result("t6_clr", 1, 64'sd48 <<< 32, 1, 0);

        // Two results queued, then reset mid-window.
        send_window(F_ONE);
        send_window(F_ONE);
        repeat (12) @(negedge clk);
        check("pre_rst_o_valid", o_valid, 1);
        for (int b = 0; b < 5; b++) send_beat(F_ONE);
        i_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_o_valid", o_valid, 0);
        check("mid_rst_i_ready", i_ready, 1);
        check("mid_rst_sw_id", sw_id, 0);
        check("mid_rst_cfg_rdata", cfg_rdata, 0);
        @(negedge clk);
        rst = 1'b1;

        // Coefficients survive reset; readback lags the address by one cycle.
        cfg_cls  = 2'd2;
        cfg_addr = 4'd9;
        @(negedge clk);
        check("rb_bank2", cfg_rdata, 3 <<< FEA_F);
        cfg_cls  = 2'd3;
        cfg_addr = 4'd0;
        check("rb_hold", cfg_rdata, 3 <<< FEA_F);
        @(negedge clk);
        check("rb_bank3", cfg_rdata, 2 <<< FEA_F);

        send_window(F_ONE);
        wait_result(lat);
        check_result("t7_post_rst", 1, 64'sd48 <<< 32, 1, 0);
        check("final_empty", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
